// File: rtl/mintz80_mmu_pkg.sv
// Shared constants for the MintZ80 paged MMU: register map, lock keys,
// page-entry bit positions and the lock-state encoding.
package mintz80_mmu_pkg;

  localparam logic [3:0] OFF_CLKDIV = 4'h0;
  localparam logic [3:0] OFF_BEEP   = 4'h1;
  localparam logic [3:0] OFF_LOCK   = 4'h2;
  localparam logic [3:0] OFF_STATUS = 4'h3;
  localparam logic [3:0] OFF_PAGE   = 4'h8;

  localparam logic [7:0] LOCK_VAL   = 8'h00;
  localparam logic [7:0] KEY_FIRST  = 8'hA5;
  localparam logic [7:0] KEY_SECOND = 8'h5A;

  localparam int unsigned ENT_WP  = 7;
  localparam int unsigned ENT_ROM = 6;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    KEY1     = 2'd2
  } lock_state_t;

endpackage

// File: rtl/mintz80_mmu_paged_strobe_sync.sv
// 2-FF synchroniser for an active-low Z80 strobe with a one-clk pulse on assertion.
module mmu_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n,
  output logic pulse
);

  logic [2:0] sync;

  // Resetting to "asserted" means a strobe held across reset release yields no pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 3'b111;
    else        sync <= {sync[1:0], ~strobe_n};
  end

  assign pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/mintz80_mmu_paged.sv
// MintZ80 second-generation MMU: IO-mapped page table with write protect,
// lock sequence, sticky fault flag, CPU clock divider and beeper.
module mintz80_mmu_paged
  import mintz80_mmu_pkg::*;
#(
  parameter logic [7:0]  IO_BASE  = 8'hD0,
  parameter int unsigned PAGES    = 8,
  parameter int unsigned BANK_W   = 5,
  parameter int unsigned DIV_W    = 4,
  parameter int unsigned BEEP_PRE = 6,
  localparam int unsigned PIDX    = $clog2(PAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iorq_n,
  input  logic              mreq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [7:0]        a_lo,
  input  logic [PIDX-1:0]   a_hi,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic [BANK_W-1:0] mem_bank,
  output logic              rom_cs_n,
  output logic              ram_cs_n,
  output logic              wp_fault,
  output logic              sysclk,
  output logic              beep
);

  localparam logic [7:0]  ENT_MASK = 8'hC0 | 8'((1 << BANK_W) - 1);
  localparam int unsigned BCW      = 8 + BEEP_PRE;

  logic [7:0]       entry [PAGES];
  logic [DIV_W-1:0] clkdiv_reg, div_act, div_cnt;
  logic [7:0]       beep_period;
  logic [BCW-1:0]   beep_cnt, beep_lim;
  logic             fault;
  lock_state_t      lock_state;

  logic io_wr_pulse, io_rd_pulse, mem_wr_pulse;
  logic hit, pg_ok, rd_valid;
  logic [3:0] offset;
  logic [PIDX-1:0] pg_idx;
  logic [7:0] rd_data;
  logic wr_hit, wr_beep;

  mmu_strobe_sync u_io_wr  (.clk(clk), .reset(reset), .strobe_n(iorq_n | wr_n),  .pulse(io_wr_pulse));
  mmu_strobe_sync u_io_rd  (.clk(clk), .reset(reset), .strobe_n(iorq_n | rd_n),  .pulse(io_rd_pulse));
  mmu_strobe_sync u_mem_wr (.clk(clk), .reset(reset), .strobe_n(mreq_n | wr_n),  .pulse(mem_wr_pulse));

  assign hit     = (a_lo[7:4] == IO_BASE[7:4]);
  assign offset  = a_lo[3:0];
  assign pg_ok   = (offset >= OFF_PAGE) && (32'(offset - OFF_PAGE) < PAGES);
  assign pg_idx  = PIDX'(offset - OFF_PAGE);
  assign wr_hit  = io_wr_pulse & hit;
  assign wr_beep = wr_hit && (offset == OFF_BEEP);

  // Combinational register read mux; offset 0x2 is write-only.
  always_comb begin
    rd_data  = 8'h00;
    rd_valid = 1'b0;
    if (offset == OFF_CLKDIV) begin
      rd_data  = 8'(clkdiv_reg);
      rd_valid = 1'b1;
    end else if (offset == OFF_BEEP) begin
      rd_data  = beep_period;
      rd_valid = 1'b1;
    end else if (offset == OFF_STATUS) begin
      rd_data  = {6'b0, fault, lock_state != UNLOCKED};
      rd_valid = 1'b1;
    end else if (pg_ok) begin
      rd_data  = entry[pg_idx];
      rd_valid = 1'b1;
    end
  end

  assign data_out = rd_data;
  assign data_oe  = !iorq_n && !rd_n && hit && rd_valid;

  assign mem_bank = BANK_W'(entry[a_hi]);
  assign rom_cs_n = mreq_n | ~entry[a_hi][ENT_ROM];
  assign ram_cs_n = mreq_n | entry[a_hi][ENT_ROM] | (entry[a_hi][ENT_WP] & ~wr_n);
  assign wp_fault = fault;

  // Register file, lock FSM and sticky fault flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PAGES; i++)
        entry[i] <= (i == 0) ? 8'h40 : (8'(i) & ENT_MASK);
      clkdiv_reg  <= '0;
      beep_period <= 8'h00;
      lock_state  <= UNLOCKED;
      fault       <= 1'b0;
    end else begin
      if (wr_hit) begin
        if (offset == OFF_CLKDIV) clkdiv_reg  <= DIV_W'(data_in);
        if (offset == OFF_BEEP)   beep_period <= data_in;
        if (pg_ok && lock_state == UNLOCKED) entry[pg_idx] <= data_in & ENT_MASK;
        case (lock_state)
          UNLOCKED: if (offset == OFF_LOCK && data_in == LOCK_VAL)  lock_state <= LOCKED;
          LOCKED:   if (offset == OFF_LOCK && data_in == KEY_FIRST) lock_state <= KEY1;
          KEY1:     lock_state <= (offset == OFF_LOCK && data_in == KEY_SECOND) ? UNLOCKED : LOCKED;
          default:  lock_state <= LOCKED;
        endcase
      end
      // Set has priority over the status-read clear.
      if (mem_wr_pulse && entry[a_hi][ENT_WP] && !entry[a_hi][ENT_ROM])
        fault <= 1'b1;
      else if (io_rd_pulse && hit && offset == OFF_STATUS)
        fault <= 1'b0;
    end
  end

  // CPU clock divider; the divisor is only picked up at a wrap so phases never shorten.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      div_act <= '0;
      sysclk  <= 1'b0;
    end else if (div_cnt == div_act) begin
      div_cnt <= '0;
      div_act <= clkdiv_reg;
      sysclk  <= ~sysclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign beep_lim = {beep_period, {BEEP_PRE{1'b0}}} - BCW'(1);

  // Beeper: toggles every period * 2^BEEP_PRE clocks, silent when period is 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beep_cnt <= '0;
      beep     <= 1'b0;
    end else if (wr_beep) begin
      beep_cnt <= '0;
      if (data_in == 8'h00) beep <= 1'b0;
    end else if (beep_period == 8'h00) begin
      beep_cnt <= '0;
      beep     <= 1'b0;
    end else if (beep_cnt == beep_lim) begin
      beep_cnt <= '0;
      beep     <= ~beep;
    end else begin
      beep_cnt <= beep_cnt + BCW'(1);
    end
  end

endmodule

// File: tb/tb_mintz80_mmu_paged.sv
// Directed self-checking bench for mintz80_mmu_paged with default parameters.
module tb_mintz80_mmu_paged;

  localparam logic [7:0] BASE = 8'hD0;

  logic       clk = 1'b0;
  logic       reset;
  logic       iorq_n, mreq_n, rd_n, wr_n;
  logic [7:0] a_lo;
  logic [2:0] a_hi;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic [4:0] mem_bank;
  logic       rom_cs_n, ram_cs_n, wp_fault, sysclk, beep;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mintz80_mmu_paged dut (
    .clk(clk), .reset(reset),
    .iorq_n(iorq_n), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .a_lo(a_lo), .a_hi(a_hi), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .mem_bank(mem_bank),
    .rom_cs_n(rom_cs_n), .ram_cs_n(ram_cs_n), .wp_fault(wp_fault),
    .sysclk(sysclk), .beep(beep)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic io_write(input logic [3:0] off, input logic [7:0] val);
    @(negedge clk);
    a_lo = BASE | {4'h0, off}; data_in = val; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (5) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic io_read(input logic [3:0] off, output logic [7:0] val, output logic oe);
    @(negedge clk);
    a_lo = BASE | {4'h0, off}; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    val = data_out; oe = data_oe;
    repeat (5) @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Waits for the next change of sysclk (sel=0) or beep (sel=1); returns the cycle stamp.
  task automatic wait_edge(input int sel, input int budget, output int at);
    logic prev, cur;
    at = -1;
    prev = (sel == 0) ? sysclk : beep;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      cur = (sel == 0) ? sysclk : beep;
      if (cur != prev) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL edge_timeout sel=%0d: no toggle within %0d clk", sel, budget);
    end
  endtask

  logic [7:0] rv;
  logic       oe;
  int t0, t1, t2;

  initial begin
    reset = 1'b0; iorq_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    a_lo = 8'h00; a_hi = 3'd0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_sysclk", 32'(sysclk), 32'd0);
    check("rst_beep", 32'(beep), 32'd0);
    check("rst_fault", 32'(wp_fault), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Page table reset contents.
    for (int i = 0; i < 8; i++) begin
      io_read(4'(8 + i), rv, oe);
      check($sformatf("rst_entry%0d", i), 32'(rv), (i == 0) ? 32'h40 : 32'(i));
      check($sformatf("rst_entry%0d_oe", i), 32'(oe), 32'd1);
    end
    io_read(4'h2, rv, oe);
    check("lock_reg_no_drive", 32'(oe), 32'd0);
    io_read(4'h5, rv, oe);
    check("unused_no_drive", 32'(oe), 32'd0);

    // Memory decode.
    @(negedge clk); mreq_n = 1'b0; a_hi = 3'd0; #1;
    check("rom_cs_page0", 32'(rom_cs_n), 32'd0);
    check("ram_cs_page0", 32'(ram_cs_n), 32'd1);
    check("bank_page0", 32'(mem_bank), 32'd0);
    a_hi = 3'd3; #1;
    check("ram_cs_page3", 32'(ram_cs_n), 32'd0);
    check("rom_cs_page3", 32'(rom_cs_n), 32'd1);
    check("bank_page3", 32'(mem_bank), 32'd3);
    mreq_n = 1'b1;

    // Write-protect and fault.
    io_write(4'h9, 8'h85);
    io_read(4'h9, rv, oe);
    check("entry1_wr", 32'(rv), 32'h85);
    @(negedge clk); a_hi = 3'd1; mreq_n = 1'b0; wr_n = 1'b0; #1;
    check("wp_ram_cs", 32'(ram_cs_n), 32'd1);
    check("wp_bank", 32'(mem_bank), 32'd5);
    repeat (5) @(negedge clk);
    mreq_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    check("fault_set", 32'(wp_fault), 32'd1);
    io_read(4'h3, rv, oe);
    check("status_fault", 32'(rv), 32'h02);
    check("fault_cleared", 32'(wp_fault), 32'd0);

    // Lock / unlock.
    io_write(4'h2, 8'h00);
    io_read(4'h3, rv, oe);
    check("status_locked", 32'(rv), 32'h01);
    io_write(4'hA, 8'h1F);
    io_read(4'hA, rv, oe);
    check("locked_entry_drop", 32'(rv), 32'h02);
    io_write(4'h2, 8'hA5);
    io_write(4'h2, 8'h5A);
    io_read(4'h3, rv, oe);
    check("status_unlocked", 32'(rv), 32'h00);
    io_write(4'hA, 8'h1F);
    io_read(4'hA, rv, oe);
    check("unlocked_entry_wr", 32'(rv), 32'h1F);

    // Broken key sequence returns to LOCKED.
    io_write(4'h2, 8'h00);
    io_write(4'h2, 8'hA5);
    io_write(4'h1, 8'h11);
    io_write(4'h2, 8'h5A);
    io_read(4'h3, rv, oe);
    check("key_broken_locked", 32'(rv), 32'h01);
    io_read(4'h1, rv, oe);
    check("beep_wr_while_locked", 32'(rv), 32'h11);
    io_write(4'h2, 8'hA5);
    io_write(4'h2, 8'h5A);

    // Clock divider.
    io_write(4'h0, 8'h01);
    wait_edge(0, 64, t0);
    wait_edge(0, 64, t1);
    check("div1_half", 32'(t1 - t0), 32'd2);
    io_write(4'h0, 8'h03);
    io_read(4'h0, rv, oe);
    check("div_readback", 32'(rv), 32'h03);
    wait_edge(0, 64, t0);
    wait_edge(0, 64, t1);
    wait_edge(0, 64, t2);
    check("div3_half", 32'(t1 - t0), 32'd4);
    check("div3_period", 32'(t2 - t0), 32'd8);

    // Beeper.
    io_write(4'h1, 8'h02);
    wait_edge(1, 400, t0);
    wait_edge(1, 400, t1);
    check("beep_half", 32'(t1 - t0), 32'd128);
    if (!beep) wait_edge(1, 400, t2);
    check("beep_high_before_off", 32'(beep), 32'd1);
    @(negedge clk);
    a_lo = BASE | 8'h01; data_in = 8'h00; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("beep_off_3clk", 32'(beep), 32'd0);
    @(negedge clk); iorq_n = 1'b1; wr_n = 1'b1;
    repeat (200) @(negedge clk);
    check("beep_stays_off", 32'(beep), 32'd0);

    // Reset during a pending IO write strobe.
    @(negedge clk);
    reset = 1'b0;
    a_lo = BASE | 8'h01; data_in = 8'h77; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (3) @(negedge clk);
    io_read(4'h1, rv, oe);
    check("no_commit_after_reset", 32'(rv), 32'h00);
    io_read(4'h0, rv, oe);
    check("clkdiv_after_reset", 32'(rv), 32'h00);
    io_read(4'h9, rv, oe);
    check("entry1_after_reset", 32'(rv), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
